fetch_ctrl: RTL

- Fetch/branch-control stage that sits directly upstream of the program counter.
- Presents p_ct to the synchronous instruction ROM and receives the instruction one cycle later.
- Decodes that instruction's control-flow fields and drives branchType, threeBitOffset and sixBitOffset into the PC, which samples them on the next posedge.
- Sequences each instruction through FETCH/EXEC, supports a downstream stall, and detects HALT.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_ctrl_if.sv | 32 +++
 rtl/branch_decode.sv | 37 +++
 rtl/fetch_ctrl.sv | 84 ++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch/branch-control stage, the PC and the decoder.
package fetch_pkg;

    typedef enum logic [1:0] {
        BR_NEXT  = 2'b00,
        BR_SHORT = 2'b01,
        BR_LONG  = 2'b10,
        BR_HOLD  = 2'b11
    } branch_e;

    localparam logic [2:0] OP_JMP   = 3'b111;
    localparam logic [2:0] OP_CTL   = 3'b110;
    localparam logic [2:0] SUB_BZ   = 3'b000;
    localparam logic [2:0] SUB_HALT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of the fetch stage's ROM, PC and status signals; master is the fetch controller.
interface fetch_ctrl_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9,
    parameter int CNT_W   = 16
);
    logic               start;
    logic [PC_W-1:0]    p_ct;
    logic [INSTR_W-1:0] imem_rdata;
    logic               zero_flag;
    logic               stall;
    logic [PC_W-1:0]    imem_addr;
    logic [1:0]         branchType;
    logic [2:0]         threeBitOffset;
    logic [5:0]         sixBitOffset;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               done;
    logic [CNT_W-1:0]   instr_count;

    modport master (
        input  start, p_ct, imem_rdata, zero_flag, stall,
        output imem_addr, branchType, threeBitOffset, sixBitOffset,
               instr, instr_valid, done, instr_count
    );

    modport slave (
        output start, p_ct, imem_rdata, zero_flag, stall,
        input  imem_addr, branchType, threeBitOffset, sixBitOffset,
               instr, instr_valid, done, instr_count
    );
endinterface

// File: rtl/branch_decode.sv
// Combinational control-flow decode of one instruction word into a PC branch request.
module branch_decode
    import fetch_pkg::*;
(
    input  logic [8:0] instr_i,
    input  logic       zero_flag_i,
    output branch_e    branch_type_o,
    output logic [2:0] three_off_o,
    output logic [5:0] six_off_o,
    output logic       is_halt_o
);
    logic [2:0] opcode;
    logic [2:0] sub;

    assign opcode = instr_i[8:6];
    assign sub    = instr_i[5:3];

    always_comb begin
        branch_type_o = BR_NEXT;
        three_off_o   = 3'b000;
        six_off_o     = 6'b000000;
        is_halt_o     = 1'b0;
        if (opcode == OP_JMP) begin
            branch_type_o = BR_LONG;
            six_off_o     = instr_i[5:0];
        end else if (opcode == OP_CTL && sub == SUB_BZ) begin
            // Offset is only driven when the branch is taken.
            if (zero_flag_i) begin
                branch_type_o = BR_SHORT;
                three_off_o   = instr_i[2:0];
            end
        end else if (opcode == OP_CTL && sub == SUB_HALT) begin
            branch_type_o = BR_HOLD;
            is_halt_o     = 1'b1;
        end
    end
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch/branch-control stage: sequences FETCH/EXEC, applies stall override, detects HALT
// and counts retired instructions.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    fetch_ctrl_if.master  bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    branch_e    dec_bt;
    logic [2:0] dec_off3;
    logic [5:0] dec_off6;
    logic       dec_halt;

    branch_e    bt;
    logic [2:0] off3;
    logic [5:0] off6;
    logic       valid;
    logic       halted;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    branch_decode u_decode (
        .instr_i       (bus.imem_rdata),
        .zero_flag_i   (bus.zero_flag),
        .branch_type_o (dec_bt),
        .three_off_o   (dec_off3),
        .six_off_o     (dec_off6),
        .is_halt_o     (dec_halt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bt      = BR_HOLD;
        off3    = 3'b000;
        off6    = 6'b000000;
        valid   = 1'b0;
        halted  = 1'b0;
        unique case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                valid = 1'b1;
                // A stalled cycle holds the PC and keeps re-decoding until released.
                if (!bus.stall) begin
                    bt      = dec_bt;
                    off3    = dec_off3;
                    off6    = dec_off6;
                    cnt_d   = sat_inc(cnt_q);
                    state_d = dec_halt ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT:  halted = 1'b1;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign bus.imem_addr      = bus.p_ct;
    assign bus.branchType     = bt;
    assign bus.threeBitOffset = off3;
    assign bus.sixBitOffset   = off6;
    assign bus.instr          = valid ? bus.imem_rdata : '0;
    assign bus.instr_valid    = valid;
    assign bus.done           = halted;
    assign bus.instr_count    = cnt_q;
endmodule
